// File: rtl/seg_pipe_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pipe_adder_pkg : default geometry and stage-count helper              |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package seg_pipe_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

  function automatic int stage_count(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_pipe_adder_seg_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | full_adder / seg_adder : combinational SEG_W-bit ripple adder of FA cells |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module seg_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co
);

  // Per-bit scalar carries keep the chain free of self-referencing vectors.
  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_lsb
      assign c_in = ci;
    end else begin : g_chain
      assign c_in = g_bit[i-1].c_out;
    end
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_in),
      .s  (s[i]),
      .co (c_out)
    );
  end

  assign co = g_bit[SEG_W-1].c_out;

endmodule
`default_nettype wire

// File: rtl/seg_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pipe_adder : WIDTH-bit adder, one SEG_W segment per pipeline stage    |
// | Optional subtract/overflow via SEG_PIPE_ADDER_SUB_EN.  rev 1.0            |
// +--------------------------------------------------------------------------+
module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEG_PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef SEG_PIPE_ADDER_SUB_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int STAGES = stage_count(WIDTH, SEG_W);

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef SEG_PIPE_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Stage k holds the low (k+1) sum segments plus the operand bits not yet summed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SUM_W = (k + 1) * SEG_W;
    localparam int REM_W = WIDTH - SUM_W;

    logic [SEG_W-1:0] a_seg;
    logic [SEG_W-1:0] b_seg;
    logic [SEG_W-1:0] seg_s;
    logic             c_in;
    logic             v_in;
    logic             seg_co;
    logic [SUM_W-1:0] sum_nx;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             valid_d;
    logic             valid_q;

    if (k == 0) begin : g_head
      assign a_seg  = a[SEG_W-1:0];
      assign b_seg  = b_eff[SEG_W-1:0];
      assign c_in   = cin_eff;
      assign v_in   = in_valid;
      assign sum_nx = seg_s;
    end else begin : g_body
      assign a_seg  = g_stage[k-1].g_rem.a_rem_q[SEG_W-1:0];
      assign b_seg  = g_stage[k-1].g_rem.b_rem_q[SEG_W-1:0];
      assign c_in   = g_stage[k-1].carry_q;
      assign v_in   = g_stage[k-1].valid_q;
      assign sum_nx = {seg_s, g_stage[k-1].sum_q};
    end

    seg_adder #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a  (a_seg),
      .b  (b_seg),
      .ci (c_in),
      .s  (seg_s),
      .co (seg_co)
    );

    always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = valid_q;
      if (advance) begin
        sum_d   = sum_nx;
        carry_d = seg_co;
        valid_d = v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] a_rem_nx;
      logic [REM_W-1:0] b_rem_nx;
      logic [REM_W-1:0] a_rem_d;
      logic [REM_W-1:0] b_rem_d;
      logic [REM_W-1:0] a_rem_q;
      logic [REM_W-1:0] b_rem_q;

      if (k == 0) begin : g_src_in
        assign a_rem_nx = a[WIDTH-1:SEG_W];
        assign b_rem_nx = b_eff[WIDTH-1:SEG_W];
      end else begin : g_src_pipe
        assign a_rem_nx = g_stage[k-1].g_rem.a_rem_q[REM_W+SEG_W-1:SEG_W];
        assign b_rem_nx = g_stage[k-1].g_rem.b_rem_q[REM_W+SEG_W-1:SEG_W];
      end

      always_comb begin
        a_rem_d = a_rem_q;
        b_rem_d = b_rem_q;
        if (advance) begin
          a_rem_d = a_rem_nx;
          b_rem_d = b_rem_nx;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;

`ifdef SEG_PIPE_ADDER_SUB_EN
  logic ovf_nx;
  logic ovf_d;
  logic ovf_q;

  // The top segment carries both operand sign bits, so overflow is decided there.
  assign ovf_nx = (g_stage[STAGES-1].a_seg[SEG_W-1] == g_stage[STAGES-1].b_seg[SEG_W-1]) &&
                  (g_stage[STAGES-1].seg_s[SEG_W-1] != g_stage[STAGES-1].a_seg[SEG_W-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (advance) begin
      ovf_d = ovf_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_pipe_adder : vector table + scoreboard bench for seg_pipe_adder    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_seg_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int SEG_W  = 4;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef SEG_PIPE_ADDER_SUB_EN
  logic             sub = 1'b0;
  logic             ovf;
`endif

  always #5 clk = ~clk;

  seg_pipe_adder #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEG_PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef SEG_PIPE_ADDER_SUB_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  vec_t        tbl [12];
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_pass = 0;
  int          n_total = 0;
  int          negcnt = 0;
  logic [15:0] cur_s = '0;
  logic        cur_c = 1'b0;
  logic        cur_ovf = 1'b0;
  bit          cur_lat = 1'b0;
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
  endtask

  function automatic logic sovf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] r);
    return (x[15] == y[15]) && (r[15] != x[15]);
  endfunction

  // Scoreboard: push on accept, pop and compare on retire.
  always @(negedge clk) begin
    negcnt++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {15'b0, cout, s}, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          check("sum", {16'b0, s}, {16'b0, mon_e.s});
          check("cout", {31'b0, cout}, {31'b0, mon_e.cout});
`ifdef SEG_PIPE_ADDER_SUB_EN
          check("ovf", {31'b0, ovf}, {31'b0, mon_e.ovf});
`endif
          if (mon_e.lat) check("latency", negcnt - mon_e.acc, STAGES);
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_s, cur_c, cur_ovf, negcnt, cur_lat});
    end
  end

  task automatic set_beat(input vec_t v, input bit lat);
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    cur_s    = v.s;
    cur_c    = v.cout;
    cur_ovf  = sovf(v.a, v.b, v.s);
    cur_lat  = lat;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int k = 0;
    forever begin
      @(negedge clk);
      if (in_ready || k > 200) break;
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    if (k > 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input vec_t v, input bit lat);
    set_beat(v, lat);
    wait_accept();
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [31:0] r;
    logic [16:0] sum17;

    tbl[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    tbl[3]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    tbl[4]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    tbl[9]  = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0};
    tbl[10] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    tbl[11] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_s", {16'b0, s}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Single beats, latency checked
    send(tbl[0], 1'b1);
    drain();
    send(tbl[1], 1'b1);
    drain();

    // Back-to-back beats
    for (int i = 2; i <= 4; i++) send(tbl[i], 1'b1);
    drain();

    // Whole table streamed
    for (int i = 0; i < 12; i++) send(tbl[i], 1'b1);
    drain();

    // Fill pipeline with output stalled, hold 5 cycles, then release
    out_ready = 1'b0;
    for (int i = 8; i <= 11; i++) send(tbl[i], 1'b0);
    set_beat(tbl[0], 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_s", {16'b0, s}, {16'b0, tbl[8].s});
      check("stall_cout", {31'b0, cout}, {31'b0, tbl[8].cout});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Reset with three beats in flight
    for (int i = 5; i <= 7; i++) send(tbl[i], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_s", {16'b0, s}, 32'd0);
    check("flush_cout", {31'b0, cout}, 32'd0);
    repeat (8) begin
      @(negedge clk);
      check("flush_no_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(tbl[0], 1'b1);
    drain();

    // Random operands with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r       = $urandom;
      v.a     = r[15:0];
      v.b     = r[31:16];
      r       = $urandom;
      v.cin   = r[0];
      sum17   = {1'b0, v.a} + {1'b0, v.b} + {16'b0, v.cin};
      v.s     = sum17[15:0];
      v.cout  = sum17[16];
      send(v, 1'b0);
    end
    rand_bp = 1'b0;
    drain();

`ifdef SEG_PIPE_ADDER_SUB_EN
    sub = 1'b1;
    v   = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1};
    set_beat(v, 1'b1);
    cur_ovf = 1'b1;
    wait_accept();
    sub = 1'b0;
    v   = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    set_beat(v, 1'b1);
    cur_ovf = 1'b1;
    wait_accept();
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
